// File: rtl/ibex_pkg.sv
// Shared types for the register-file write-port arbiter.
//   rf_arb_state_e : write-stage sequencing state (single write vs. pending pair high half)
//   RfArbPtrW      : round-robin pointer width for the default requester count
//   rf_arb_ptr_w() : pointer width for an arbitrary requester count (minimum 1 bit)
package ibex_pkg;

    typedef enum logic [0:0] {
        RfArbIdle   = 1'b0,
        RfArbPairHi = 1'b1
    } rf_arb_state_e;

    localparam int unsigned RfAddrW            = 5;
    localparam int unsigned RfArbNumReqDefault = 3;
    localparam int unsigned RfArbPtrW          = $clog2(RfArbNumReqDefault);

    function automatic int unsigned rf_arb_ptr_w(input int unsigned num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/ibex_rf_rr_arbiter.sv
// Pure combinational round-robin grant: first valid requester at or after ptr_i.
//   valid_i     : request vector
//   ptr_i       : highest-priority index (always < NumReq)
//   gnt_o       : one-hot grant
//   gnt_idx_o   : index of the granted requester
//   gnt_valid_o : some requester was granted
module ibex_rf_rr_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned NumReq = 3,
    parameter int unsigned PtrW   = rf_arb_ptr_w(NumReq)
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [PtrW-1:0]   gnt_idx_o,
    output logic              gnt_valid_o
);

    localparam int unsigned SumW = PtrW + 1;

    logic [SumW-1:0] sum;
    logic [PtrW-1:0] idx;
    logic            found;

    // Scan from the pointer upward, wrapping modulo NumReq.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            sum = {1'b0, ptr_i} + SumW'(i);
            if (sum >= SumW'(NumReq)) begin
                sum = sum - SumW'(NumReq);
            end
            idx = sum[PtrW-1:0];
            if (!found && valid_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
        gnt_valid_o = found;
    end

endmodule

// File: rtl/ibex_rf_wport_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between NumReq
// writeback requesters, with one registered write stage and two-cycle pair writes (rd, rd+1).
// Optional macro IBEX_RF_ARB_FWD_EN enables combinational forwarding from the write stage.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   req_valid_i / req_ready_o      per-requester handshake (ready is same-cycle grant)
//   req_waddr_i, req_wdata_i       destination rd and its data
//   req_wdata_hi_i, req_pair_i     rd+1 data and pair request flag
//   rf_waddr_o/rf_wdata_o/rf_we_o  register file write port (registered)
//   busy_o                         write stage occupied or pair high half pending
//   err_o                          one-cycle pulse: illegal request dropped
//   fwd_raddr_i/fwd_hit_o/fwd_data_o  forwarding lookup against the write stage
module ibex_rf_wport_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned NumReq    = 3,
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0,
    parameter bit          PairWrite = 1'b1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0][RfAddrW-1:0]      req_waddr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_hi_i,
    input  logic [NumReq-1:0]                   req_pair_i,
    output logic [RfAddrW-1:0]                  rf_waddr_o,
    output logic [DataWidth-1:0]                rf_wdata_o,
    output logic                                rf_we_o,
    output logic                                busy_o,
    output logic                                err_o,
    input  logic [RfAddrW-1:0]                  fwd_raddr_i,
    output logic                                fwd_hit_o,
    output logic [DataWidth-1:0]                fwd_data_o
);

    localparam int unsigned   PtrW    = rf_arb_ptr_w(NumReq);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NumReq - 1);

    rf_arb_state_e        state_q;
    logic [PtrW-1:0]      ptr_q;
    logic                 we_q;
    logic                 err_q;
    logic [RfAddrW-1:0]   waddr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [DataWidth-1:0] hi_data_q;

    logic [NumReq-1:0]    gnt;
    logic [PtrW-1:0]      gnt_idx;
    logic                 gnt_valid;

    ibex_rf_rr_arbiter #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_rr_arbiter (
        .valid_i     (req_valid_i),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Grants are only offered while no pair high half is pending.
    logic hs_c;
    assign hs_c        = gnt_valid && (state_q == RfArbIdle);
    assign req_ready_o = hs_c ? gnt : '0;

    logic [RfAddrW-1:0]   sel_addr_c;
    logic [DataWidth-1:0] sel_data_c;
    logic [DataWidth-1:0] sel_data_hi_c;
    logic                 sel_pair_c;
    logic                 sel_err_c;

    // Mux the granted request and classify it. An even pair rd keeps rd+1 in the same
    // 16-register half, so for RV32E rd[4] alone covers the rd+1 > 15 case; odd pair rd
    // (including rd=31) is always illegal.
    always_comb begin
        sel_addr_c    = req_waddr_i[gnt_idx];
        sel_data_c    = req_wdata_i[gnt_idx];
        sel_data_hi_c = req_wdata_hi_i[gnt_idx];
        sel_pair_c    = PairWrite && req_pair_i[gnt_idx];
        sel_err_c     = 1'b0;
        if (sel_pair_c && sel_addr_c[0]) begin
            sel_err_c = 1'b1;
        end
        if (RV32E && sel_addr_c[4]) begin
            sel_err_c = 1'b1;
        end
    end

    // Write stage, RR pointer and pair sequencing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RfArbIdle;
            ptr_q     <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            hi_data_q <= '0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            if (hs_c) begin
                ptr_q <= (gnt_idx == LastIdx) ? '0 : gnt_idx + PtrW'(1);
            end
            unique case (state_q)
                RfArbIdle: begin
                    if (hs_c) begin
                        waddr_q <= sel_addr_c;
                        wdata_q <= sel_data_c;
                        err_q   <= sel_err_c;
                        // x0 completes the handshake but is never written
                        we_q    <= !sel_err_c && (sel_addr_c != '0);
                        if (sel_pair_c && !sel_err_c) begin
                            state_q   <= RfArbPairHi;
                            hi_data_q <= sel_data_hi_c;
                        end
                    end
                end
                RfArbPairHi: begin
                    // Low half address is even, so rd+1 is rd with bit 0 set.
                    we_q    <= 1'b1;
                    waddr_q <= waddr_q | RfAddrW'(1);
                    wdata_q <= hi_data_q;
                    state_q <= RfArbIdle;
                end
                default: state_q <= RfArbIdle;
            endcase
        end
    end

    assign rf_we_o    = we_q;
    assign rf_waddr_o = waddr_q;
    assign rf_wdata_o = wdata_q;
    assign err_o      = err_q;
    assign busy_o     = we_q || (state_q == RfArbPairHi);

`ifdef IBEX_RF_ARB_FWD_EN
    // Forward the registered write that has not yet landed in the register file.
    assign fwd_hit_o  = we_q && (waddr_q == fwd_raddr_i);
    assign fwd_data_o = wdata_q;
`else
    logic [RfAddrW-1:0] unused_fwd_raddr;
    assign unused_fwd_raddr = fwd_raddr_i;
    assign fwd_hit_o        = 1'b0;
    assign fwd_data_o       = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
// Directed bench for ibex_rf_wport_arbiter: a vector table of single-cycle handshakes
// followed by hand-written multi-cycle sequences (pairs, RV32E, reset mid-pair, forwarding).
module tb_ibex_rf_wport_arbiter;

    localparam int unsigned NumReq = 3;
    localparam int unsigned DW     = 32;
`ifdef IBEX_RF_ARB_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [NumReq-1:0]          req_valid;
    logic [NumReq-1:0][4:0]     req_waddr;
    logic [NumReq-1:0][DW-1:0]  req_wdata;
    logic [NumReq-1:0][DW-1:0]  req_wdata_hi;
    logic [NumReq-1:0]          req_pair;
    logic [4:0]                 fwd_raddr;

    logic [NumReq-1:0] req_ready, e_req_ready;
    logic [4:0]        rf_waddr, e_rf_waddr;
    logic [DW-1:0]     rf_wdata, e_rf_wdata, fwd_data, e_fwd_data;
    logic              rf_we, e_rf_we, busy, e_busy, err, e_err, fwd_hit, e_fwd_hit;

    ibex_rf_wport_arbiter #(.NumReq(NumReq), .DataWidth(DW), .RV32E(1'b0), .PairWrite(1'b1)) dut (
        .clk_i (clk_i), .rst_ni (rst_ni),
        .req_valid_i (req_valid), .req_ready_o (req_ready),
        .req_waddr_i (req_waddr), .req_wdata_i (req_wdata),
        .req_wdata_hi_i (req_wdata_hi), .req_pair_i (req_pair),
        .rf_waddr_o (rf_waddr), .rf_wdata_o (rf_wdata), .rf_we_o (rf_we),
        .busy_o (busy), .err_o (err),
        .fwd_raddr_i (fwd_raddr), .fwd_hit_o (fwd_hit), .fwd_data_o (fwd_data)
    );

    ibex_rf_wport_arbiter #(.NumReq(NumReq), .DataWidth(DW), .RV32E(1'b1), .PairWrite(1'b1)) dut_e (
        .clk_i (clk_i), .rst_ni (rst_ni),
        .req_valid_i (req_valid), .req_ready_o (e_req_ready),
        .req_waddr_i (req_waddr), .req_wdata_i (req_wdata),
        .req_wdata_hi_i (req_wdata_hi), .req_pair_i (req_pair),
        .rf_waddr_o (e_rf_waddr), .rf_wdata_o (e_rf_wdata), .rf_we_o (e_rf_we),
        .busy_o (e_busy), .err_o (e_err),
        .fwd_raddr_i (fwd_raddr), .fwd_hit_o (e_fwd_hit), .fwd_data_o (e_fwd_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input int i, input logic [4:0] a);
        return {16'hA5A5, 8'(i), 3'b000, a};
    endfunction

    task automatic clear_inputs();
        req_valid    = '0;
        req_waddr    = '0;
        req_wdata    = '0;
        req_wdata_hi = '0;
        req_pair     = '0;
        fwd_raddr    = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  pair;
        logic [4:0]  a0, a1, a2;
        logic [2:0]  exp_rdy;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // valid/pair/ready are {req2, req1, req0}; data of requester i at rd a is data_of(i, a)
        vecs[0] = '{3'b001, 3'b000, 5'd5,  5'd6,  5'd7,  3'b001, 1'b1, 5'd5,  32'hA5A5_0005, 1'b0};
        vecs[1] = '{3'b111, 3'b000, 5'd1,  5'd2,  5'd3,  3'b010, 1'b1, 5'd2,  32'hA5A5_0102, 1'b0};
        vecs[2] = '{3'b111, 3'b000, 5'd1,  5'd2,  5'd3,  3'b100, 1'b1, 5'd3,  32'hA5A5_0203, 1'b0};
        vecs[3] = '{3'b111, 3'b000, 5'd1,  5'd2,  5'd3,  3'b001, 1'b1, 5'd1,  32'hA5A5_0001, 1'b0};
        vecs[4] = '{3'b101, 3'b000, 5'd8,  5'd9,  5'd10, 3'b100, 1'b1, 5'd10, 32'hA5A5_020A, 1'b0};
        vecs[5] = '{3'b000, 3'b000, 5'd8,  5'd9,  5'd10, 3'b000, 1'b0, 5'd0,  32'h0,          1'b0};
        vecs[6] = '{3'b110, 3'b000, 5'd4,  5'd0,  5'd12, 3'b010, 1'b0, 5'd0,  32'h0,          1'b0};
        vecs[7] = '{3'b011, 3'b000, 5'd13, 5'd14, 5'd15, 3'b001, 1'b1, 5'd13, 32'hA5A5_000D, 1'b0};
        vecs[8] = '{3'b010, 3'b010, 5'd0,  5'd7,  5'd0,  3'b010, 1'b0, 5'd0,  32'h0,          1'b1};
        vecs[9] = '{3'b100, 3'b000, 5'd0,  5'd0,  5'd31, 3'b100, 1'b1, 5'd31, 32'hA5A5_021F, 1'b0};

        // Reset state and a lone single write
        do_reset();
        #1;
        chk("rst we", 64'(rf_we), 64'd0);
        chk("rst addr", 64'(rf_waddr), 64'd0);
        chk("rst data", 64'(rf_wdata), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        chk("rst ready", 64'(req_ready), 64'd0);
        chk("rst hit", 64'(fwd_hit), 64'd0);
        @(negedge clk_i);
        req_valid    = 3'b001;
        req_waddr[0] = 5'd5;
        req_wdata[0] = 32'hA5A5_0001;
        #1 chk("single ready", 64'(req_ready), 64'b001);
        @(posedge clk_i); #1;
        chk("single we", 64'(rf_we), 64'd1);
        chk("single addr", 64'(rf_waddr), 64'd5);
        chk("single data", 64'(rf_wdata), 64'hA5A5_0001);
        chk("single busy", 64'(busy), 64'd1);
        @(negedge clk_i);
        clear_inputs();
        @(posedge clk_i); #1;
        chk("single we drop", 64'(rf_we), 64'd0);

        // Vector table, starting from pointer 0
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            req_valid    = vecs[k].valid;
            req_pair     = vecs[k].pair;
            req_waddr[0] = vecs[k].a0;
            req_waddr[1] = vecs[k].a1;
            req_waddr[2] = vecs[k].a2;
            for (int r = 0; r < 3; r++) begin
                req_wdata[r]    = data_of(r, req_waddr[r]);
                req_wdata_hi[r] = 32'hFFFF_0000;
            end
            fwd_raddr = vecs[k].exp_addr;
            #1 chk($sformatf("v%0d ready", k), 64'(req_ready), 64'(vecs[k].exp_rdy));
            @(posedge clk_i); #1;
            chk($sformatf("v%0d we", k), 64'(rf_we), 64'(vecs[k].exp_we));
            chk($sformatf("v%0d err", k), 64'(err), 64'(vecs[k].exp_err));
            chk($sformatf("v%0d busy", k), 64'(busy), 64'(vecs[k].exp_we));
            chk($sformatf("v%0d hit", k), 64'(fwd_hit), 64'(FwdEn && vecs[k].exp_we));
            if (vecs[k].exp_we) begin
                chk($sformatf("v%0d addr", k), 64'(rf_waddr), 64'(vecs[k].exp_addr));
                chk($sformatf("v%0d data", k), 64'(rf_wdata), 64'(vecs[k].exp_data));
            end
        end
        @(negedge clk_i);
        clear_inputs();

        // All three held valid: grants rotate 0,1,2,... with a write every cycle
        do_reset();
        for (int r = 0; r < 3; r++) begin
            req_waddr[r] = 5'(r + 1);
            req_wdata[r] = data_of(r, 5'(r + 1));
        end
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1 chk($sformatf("rr%0d ready", c), 64'(req_ready), 64'(3'b001 << (c % 3)));
            @(posedge clk_i); #1;
            chk($sformatf("rr%0d we", c), 64'(rf_we), 64'd1);
            chk($sformatf("rr%0d addr", c), 64'(rf_waddr), 64'((c % 3) + 1));
            @(negedge clk_i);
        end
        clear_inputs();

        // Pair from req1 while req0 waits; pointer first moved to 1 by a req0 write
        do_reset();
        req_valid    = 3'b001;
        req_waddr[0] = 5'd1;
        req_wdata[0] = 32'h0000_0099;
        @(negedge clk_i);
        req_valid       = 3'b011;
        req_waddr[0]    = 5'd4;
        req_wdata[0]    = 32'h0000_0044;
        req_pair[1]     = 1'b1;
        req_waddr[1]    = 5'd10;
        req_wdata[1]    = 32'h0000_0011;
        req_wdata_hi[1] = 32'h0000_0022;
        #1 chk("pair ready", 64'(req_ready), 64'b010);
        @(posedge clk_i); #1;
        req_valid[1] = 1'b0;
        chk("pair lo we", 64'(rf_we), 64'd1);
        chk("pair lo addr", 64'(rf_waddr), 64'd10);
        chk("pair lo data", 64'(rf_wdata), 64'h11);
        chk("pair lo busy", 64'(busy), 64'd1);
        #1 chk("pair hi blocks ready", 64'(req_ready), 64'd0);
        @(posedge clk_i); #1;
        chk("pair hi we", 64'(rf_we), 64'd1);
        chk("pair hi addr", 64'(rf_waddr), 64'd11);
        chk("pair hi data", 64'(rf_wdata), 64'h22);
        chk("pair after ready", 64'(req_ready), 64'b001);
        @(posedge clk_i); #1;
        req_valid = '0;
        chk("pair next we", 64'(rf_we), 64'd1);
        chk("pair next addr", 64'(rf_waddr), 64'd4);
        chk("pair next data", 64'(rf_wdata), 64'h44);
        @(posedge clk_i); #1;
        chk("pair idle we", 64'(rf_we), 64'd0);
        chk("pair idle busy", 64'(busy), 64'd0);
        clear_inputs();

        // Pair to x0: low half suppressed, high half to x1 still written
        do_reset();
        req_valid       = 3'b001;
        req_pair[0]     = 1'b1;
        req_waddr[0]    = 5'd0;
        req_wdata[0]    = 32'h0000_0055;
        req_wdata_hi[0] = 32'h0000_0066;
        @(posedge clk_i); #1;
        req_valid = '0;
        chk("x0pair lo we", 64'(rf_we), 64'd0);
        chk("x0pair err", 64'(err), 64'd0);
        chk("x0pair busy", 64'(busy), 64'd1);
        @(posedge clk_i); #1;
        chk("x0pair hi we", 64'(rf_we), 64'd1);
        chk("x0pair hi addr", 64'(rf_waddr), 64'd1);
        chk("x0pair hi data", 64'(rf_wdata), 64'h66);
        clear_inputs();

        // RV32E: rd=17 is dropped with a one-cycle error pulse; the RV32I instance writes it
        do_reset();
        req_valid    = 3'b001;
        req_waddr[0] = 5'd17;
        req_wdata[0] = data_of(0, 5'd17);
        #1 chk("e ready", 64'(e_req_ready), 64'b001);
        @(posedge clk_i); #1;
        req_valid = '0;
        chk("e err", 64'(e_err), 64'd1);
        chk("e we", 64'(e_rf_we), 64'd0);
        chk("i we17", 64'(rf_we), 64'd1);
        chk("i addr17", 64'(rf_waddr), 64'd17);
        @(posedge clk_i); #1;
        chk("e err pulse", 64'(e_err), 64'd0);
        clear_inputs();

        // Reset during the high half of a pair drops it
        do_reset();
        req_valid       = 3'b001;
        req_pair[0]     = 1'b1;
        req_waddr[0]    = 5'd10;
        req_wdata[0]    = 32'h0000_00AA;
        req_wdata_hi[0] = 32'h0000_00BB;
        @(posedge clk_i); #1;
        req_valid = '0;
        chk("rstpair lo we", 64'(rf_we), 64'd1);
        chk("rstpair lo addr", 64'(rf_waddr), 64'd10);
        rst_ni = 1'b0;
        #1;
        chk("rstpair we", 64'(rf_we), 64'd0);
        chk("rstpair busy", 64'(busy), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk_i); #1;
            chk($sformatf("rstpair no hi %0d", c), 64'(rf_we), 64'd0);
        end
        clear_inputs();

        // Forwarding lookup against the write stage
        do_reset();
        req_valid    = 3'b001;
        req_waddr[0] = 5'd3;
        req_wdata[0] = data_of(0, 5'd3);
        fwd_raddr    = 5'd3;
        @(posedge clk_i); #1;
        req_valid = '0;
        chk("fwd hit", 64'(fwd_hit), 64'(FwdEn));
        chk("fwd data", 64'(fwd_data), FwdEn ? 64'(32'hA5A5_0003) : 64'd0);
        fwd_raddr = 5'd4;
        #1 chk("fwd miss", 64'(fwd_hit), 64'd0);
        @(negedge clk_i);
        req_valid    = 3'b001;
        req_waddr[0] = 5'd0;
        fwd_raddr    = 5'd0;
        @(posedge clk_i); #1;
        req_valid = '0;
        chk("fwd x0", 64'(fwd_hit), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
